// File: rtl/waterfall_pkg.sv
// Shared types and defaults for the waterfall row scheduler slice.
package waterfall_pkg;

    localparam int NUM_BINS_DEF = 512;
    localparam int FFT_SIZE_DEF = 1024;

    typedef enum logic {SYNC, RUN} wf_state_t;
    typedef enum logic {MODE_LAST, MODE_MAXHOLD} wf_mode_t;

    // Unsigned 8-bit maximum used by max-hold accumulation.
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wf_line_buffer.sv
// Simple dual-port NUM_BINS x 8 line buffer with 1-cycle synchronous read
// and write-to-read bypass for a same-address access in the same cycle.
module wf_line_buffer #(
    parameter int NUM_BINS = 512,
    parameter int AW       = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data
);

    logic [7:0] mem [NUM_BINS];

    // Write port plus registered read; a colliding write is forwarded to the read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/waterfall_row_scheduler.sv
// Turns FFT magnitude frames into waterfall rows: keeps the first NUM_BINS
// bins, decimates by cfg_decim frames (LAST or per-bin MAXHOLD), honours
// freeze, and resynchronises on bad frame lengths. Fixed 2-cycle latency.
module waterfall_row_scheduler
    import waterfall_pkg::*;
#(
    parameter int NUM_BINS = NUM_BINS_DEF,
    parameter int FFT_SIZE = FFT_SIZE_DEF,
    parameter int DECIM_W  = 4
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    input  logic [7:0]         fft_data,
    input  logic               fft_valid,
    input  logic               fft_last,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic               cfg_mode,
    input  logic               cfg_freeze,
    output logic [7:0]         log_out,
    output logic               log_valid,
    output logic               log_last,
    output logic [7:0]         row_count,
    output logic               frame_err
);

    localparam int BW = $clog2(FFT_SIZE) + 1;
    localparam int AW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_SIZE - 1);
    localparam logic [BW-1:0] KEEP_BINS = BW'(NUM_BINS);
    localparam logic [BW-1:0] KEEP_LAST = BW'(NUM_BINS - 1);

    wf_state_t          state;
    logic [BW-1:0]      bin_cnt;
    logic [DECIM_W-1:0] k;
    logic [DECIM_W-1:0] d_lat;
    wf_mode_t           mode_lat;
    logic               freeze_lat;

    logic               frame_start;
    logic [DECIM_W-1:0] d_new;
    logic [DECIM_W-1:0] cur_d;
    wf_mode_t           cur_mode;
    logic               cur_freeze;
    logic [DECIM_W-1:0] cur_k;
    logic               at_end;
    logic               bad;
    logic               good_end;
    logic               accept;
    logic               is_final;

    logic               s1_valid;
    logic               s1_emit;
    logic               s1_wr;
    logic               s1_first;
    logic               s1_max;
    logic               s1_last;
    logic [7:0]         s1_data;
    logic [AW-1:0]      s1_addr;

    logic [7:0]         rd_data;
    logic [7:0]         lb_val;
    logic [7:0]         emit_val;
    logic               wr_en;

    // Effective per-frame config: live inputs on bin 0 (the latch cycle), latched copy afterwards.
    always_comb begin
        d_new       = (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
        frame_start = (state == RUN) && fft_valid && (bin_cnt == '0);
        cur_d       = frame_start ? d_new : d_lat;
        cur_mode    = frame_start ? wf_mode_t'(cfg_mode) : mode_lat;
        cur_freeze  = frame_start ? cfg_freeze : freeze_lat;
        cur_k       = (frame_start && (d_new != d_lat)) ? '0 : k;
        at_end      = (bin_cnt == LAST_BIN);
        bad         = (state == RUN) && fft_valid && (fft_last != at_end);
        good_end    = (state == RUN) && fft_valid && fft_last && at_end;
        accept      = (state == RUN) && fft_valid && !cur_freeze && (bin_cnt < KEEP_BINS);
        is_final    = (cur_k == (cur_d - DECIM_W'(1)));
    end

    // FSM, bin/frame counters, config latch and the read-stage pipeline register.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state      <= SYNC;
            bin_cnt    <= '0;
            k          <= '0;
            d_lat      <= DECIM_W'(1);
            mode_lat   <= MODE_LAST;
            freeze_lat <= 1'b0;
            frame_err  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_emit    <= 1'b0;
            s1_wr      <= 1'b0;
            s1_first   <= 1'b0;
            s1_max     <= 1'b0;
            s1_last    <= 1'b0;
            s1_data    <= '0;
            s1_addr    <= '0;
        end else begin
            frame_err <= 1'b0;

            s1_valid <= accept;
            s1_emit  <= is_final;
            s1_wr    <= (cur_mode == MODE_MAXHOLD) && !is_final;
            s1_first <= (cur_k == '0);
            s1_max   <= (cur_mode == MODE_MAXHOLD) && (cur_k != '0);
            s1_last  <= (bin_cnt == KEEP_LAST) && !bad;
            s1_data  <= fft_data;
            s1_addr  <= bin_cnt[AW-1:0];

            if (fft_valid) begin
                bin_cnt <= (fft_last || at_end) ? '0 : bin_cnt + BW'(1);
            end

            if (frame_start) begin
                d_lat      <= d_new;
                mode_lat   <= cur_mode;
                freeze_lat <= cfg_freeze;
                if (d_new != d_lat) begin
                    k <= '0;
                end
            end

            case (state)
                SYNC: begin
                    if (fft_valid && fft_last) begin
                        state <= RUN;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (bad) begin
                        state     <= SYNC;
                        k         <= '0;
                        frame_err <= 1'b1;
                    end else if (good_end && !cur_freeze) begin
                        k <= is_final ? '0 : cur_k + DECIM_W'(1);
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    wf_line_buffer #(
        .NUM_BINS (NUM_BINS),
        .AW       (AW)
    ) u_line_buffer (
        .clk     (wr_clk),
        .rd_addr (bin_cnt[AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (s1_addr),
        .wr_data (lb_val)
    );

    // Compare stage: line-buffer update value and emitted sample.
    always_comb begin
        lb_val   = s1_first ? s1_data : max8(rd_data, s1_data);
        emit_val = s1_max ? max8(rd_data, s1_data) : s1_data;
        wr_en    = s1_valid && s1_wr;
    end

    // Registered output stage and row counter.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            log_out   <= '0;
            log_valid <= 1'b0;
            log_last  <= 1'b0;
            row_count <= '0;
        end else begin
            log_valid <= s1_valid && s1_emit;
            log_last  <= s1_valid && s1_emit && s1_last;
            if (s1_valid && s1_emit) begin
                log_out <= emit_val;
            end
            if (s1_valid && s1_emit && s1_last) begin
                row_count <= row_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_waterfall_row_scheduler.sv
// Directed scoreboard bench for waterfall_row_scheduler (reduced row/frame sizes).
module tb_waterfall_row_scheduler;

    localparam int NB = 8;
    localparam int FS = 12;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic [7:0] fft_data;
    logic       fft_valid;
    logic       fft_last;
    logic [3:0] cfg_decim;
    logic       cfg_mode;
    logic       cfg_freeze;
    logic [7:0] log_out;
    logic       log_valid;
    logic       log_last;
    logic [7:0] row_count;
    logic       frame_err;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   rows_exp = 0;
    int   err_cycles = 0;

    waterfall_row_scheduler #(
        .NUM_BINS (NB),
        .FFT_SIZE (FS),
        .DECIM_W  (4)
    ) dut (
        .wr_clk     (wr_clk),
        .wr_rst     (wr_rst),
        .fft_data   (fft_data),
        .fft_valid  (fft_valid),
        .fft_last   (fft_last),
        .cfg_decim  (cfg_decim),
        .cfg_mode   (cfg_mode),
        .cfg_freeze (cfg_freeze),
        .log_out    (log_out),
        .log_valid  (log_valid),
        .log_last   (log_last),
        .row_count  (row_count),
        .frame_err  (frame_err)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    endtask

    // Output monitor: pops the scoreboard for every write strobe.
    always @(negedge wr_clk) begin
        if (!wr_rst) begin
            if (frame_err) err_cycles++;
            if (log_valid) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("log_out", 32'(log_out), 32'(e.data));
                    check("log_last", 32'(log_last), 32'(e.last));
                    check("latency", 32'(cyc), 32'(e.due));
                end
            end else if (log_last) begin
                check("last_without_valid", 32'(log_last), 32'd0);
            end
        end
    end

    // One frame of len bins at negedge boundaries; pushes expected row samples when emit is set.
    task automatic frame(input int len, input bit ramp, input logic [7:0] cval,
                         input bit emit, input bit eramp, input logic [7:0] ecval);
        for (int b = 0; b < len; b++) begin
            fft_valid = 1'b1;
            fft_data  = ramp ? 8'(b) : cval;
            fft_last  = (b == len - 1);
            if (emit && b < NB) begin
                exp_t e;
                e.data = eramp ? 8'(b) : ecval;
                e.last = (b == NB - 1) && (len == FS);
                e.due  = cyc + 2;
                sb.push_back(e);
                if (e.last) rows_exp++;
            end
            @(negedge wr_clk);
        end
    endtask

    task automatic idle(input int n);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        fft_data  = '0;
        repeat (n) @(negedge wr_clk);
    endtask

    initial begin
        wr_rst     = 1'b1;
        fft_data   = '0;
        fft_valid  = 1'b0;
        fft_last   = 1'b0;
        cfg_decim  = 4'd1;
        cfg_mode   = 1'b0;
        cfg_freeze = 1'b0;
        repeat (3) @(negedge wr_clk);
        check("rst_log_out", 32'(log_out), 32'd0);
        check("rst_log_valid", 32'(log_valid), 32'd0);
        check("rst_log_last", 32'(log_last), 32'd0);
        check("rst_row_count", 32'(row_count), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        wr_rst = 1'b0;
        @(negedge wr_clk);

        // D=1 LAST ramp: first frame only synchronises.
        frame(FS, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(4);
        check("t1_row_count", 32'(row_count), 32'd2);

        // D=4 MAXHOLD, constants 10,50,30,20 -> row of 50.
        cfg_decim = 4'd4;
        cfg_mode  = 1'b1;
        frame(FS, 1'b0, 8'd10, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd50, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd30, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd20, 1'b1, 1'b0, 8'd50);
        idle(4);
        check("t2_row_count", 32'(row_count), 32'd3);

        // D=3 LAST, 7,8,9 -> row of 9 only.
        cfg_decim = 4'd3;
        cfg_mode  = 1'b0;
        frame(FS, 1'b0, 8'd7, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd8, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd9, 1'b1, 1'b0, 8'd9);
        idle(4);
        check("t3_row_count", 32'(row_count), 32'd4);

        // Short frame: fft_last on bin 5 -> error, resync, next frame dropped.
        cfg_decim = 4'd1;
        frame(6, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(4);
        check("t4_err_pulse_cycles", 32'(err_cycles), 32'd1);
        check("t4_row_count_held", 32'(row_count), 32'd4);
        frame(FS, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(4);
        check("t4_row_count", 32'(row_count), 32'd5);
        check("t4_err_total", 32'(err_cycles), 32'd1);

        // D=2 MAXHOLD with two frozen frames of 99 -> row of 8.
        cfg_decim = 4'd2;
        cfg_mode  = 1'b1;
        frame(FS, 1'b0, 8'd5, 1'b0, 1'b0, 8'd0);
        cfg_freeze = 1'b1;
        frame(FS, 1'b0, 8'd99, 1'b0, 1'b0, 8'd0);
        frame(FS, 1'b0, 8'd99, 1'b0, 1'b0, 8'd0);
        cfg_freeze = 1'b0;
        frame(FS, 1'b0, 8'd8, 1'b1, 1'b0, 8'd8);
        idle(4);
        check("t5_row_count", 32'(row_count), 32'd6);

        // Row counter wrap with D=1.
        cfg_decim = 4'd1;
        cfg_mode  = 1'b0;
        while (rows_exp != 255) frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(3);
        check("t6_row_count_255", 32'(row_count), 32'd255);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(3);
        check("t6_row_count_wrap", 32'(row_count), 32'd0);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(3);
        check("t6_row_count_1", 32'(row_count), 32'd1);

        // Async reset in the middle of a row.
        frame(4, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        #2;
        wr_rst    = 1'b1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        #1;
        check("arst_log_valid", 32'(log_valid), 32'd0);
        check("arst_log_out", 32'(log_out), 32'd0);
        check("arst_log_last", 32'(log_last), 32'd0);
        check("arst_row_count", 32'(row_count), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        sb.delete();
        rows_exp = 0;
        @(negedge wr_clk);
        wr_rst = 1'b0;
        @(negedge wr_clk);
        frame(FS, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0);
        frame(FS, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0);
        idle(4);
        check("post_rst_row_count", 32'(row_count), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
